// File: rtl/fft_out_streamer.sv
// Captures the FFT core's parallel result bus on endop and streams it as
// N_POINTS complex beats over valid/ready. Define FFT_OUT_BITREV_EN to read bins bit-reversed.
module fft_out_streamer #(
    parameter int N_POINTS = 16,
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [2*DATA_W*N_POINTS-1:0]   Data_Out,
    input  logic                           endop,
    input  logic                           out_ready,
    input  logic                           overrun_clr,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_re,
    output logic [DATA_W-1:0]              out_im,
    output logic [IDX_W-1:0]               out_index,
    output logic                           out_last,
    output logic                           busy,
    output logic                           overrun
);

    localparam int BUS_W = 2 * DATA_W * N_POINTS;
    localparam int SMP_W = 2 * DATA_W;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] count_reg;
    logic [BUS_W-1:0] buf_reg;
    logic             overrun_reg;

    logic             streaming;
    logic             beat_xfer;
    logic             last_xfer;
    logic             capture;
    logic             drop;
    logic [IDX_W-1:0] rd_addr;
    logic [SMP_W-1:0] sample_arr [N_POINTS];
    logic [SMP_W-1:0] cur_sample;

    assign streaming = (state_reg == ST_STREAM);
    assign beat_xfer = streaming && out_ready;
    assign last_xfer = beat_xfer && (count_reg == LAST_IDX);
    // A new frame may be taken either when idle or exactly on the closing beat.
    assign capture   = endop && (!streaming || last_xfer);
    assign drop      = endop && streaming && !last_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < N_POINTS; gi++) begin : g_unpack
            assign sample_arr[gi] = buf_reg[SMP_W*gi +: SMP_W];
        end
`ifdef FFT_OUT_BITREV_EN
        for (gi = 0; gi < IDX_W; gi++) begin : g_rev
            assign rd_addr[gi] = count_reg[IDX_W-1-gi];
        end
`else
        assign rd_addr = count_reg;
`endif
    endgenerate

    assign cur_sample = sample_arr[rd_addr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            buf_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (capture) begin
                buf_reg   <= Data_Out;
                count_reg <= '0;
                state_reg <= ST_STREAM;
            end else if (last_xfer) begin
                count_reg <= '0;
                state_reg <= ST_IDLE;
            end else if (beat_xfer) begin
                count_reg <= count_reg + IDX_W'(1);
            end

            // Set has priority so a drop is never lost to a simultaneous clear.
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign out_valid = streaming;
    assign out_re    = cur_sample[SMP_W-1:DATA_W];
    assign out_im    = cur_sample[DATA_W-1:0];
    assign out_index = count_reg;
    assign out_last  = streaming && (count_reg == LAST_IDX);
    assign busy      = streaming;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_fft_out_streamer.sv
// Directed testbench for fft_out_streamer; inputs change and outputs are checked on the falling edge.
module tb_fft_out_streamer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] data_out = '0;
    logic         endop = 1'b0;
    logic         out_ready = 1'b0;
    logic         overrun_clr = 1'b0;
    logic         out_valid;
    logic [15:0]  out_re;
    logic [15:0]  out_im;
    logic [3:0]   out_index;
    logic         out_last;
    logic         busy;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_out_streamer dut (
        .clock(clk), .reset(rst), .Data_Out(data_out), .endop(endop),
        .out_ready(out_ready), .overrun_clr(overrun_clr), .out_valid(out_valid),
        .out_re(out_re), .out_im(out_im), .out_index(out_index), .out_last(out_last),
        .busy(busy), .overrun(overrun)
    );

    function automatic logic [511:0] make_frame(input logic [15:0] re_base, input logic [15:0] im_base);
        logic [511:0] bus;
        bus = '0;
        for (int k = 0; k < 16; k++) begin
            bus[32*k +: 32] = {re_base + 16'(k), im_base | 16'(k)};
        end
        return bus;
    endfunction

    // Which bus sample the bench expects on beat i.
    function automatic logic [3:0] src_of(input int i);
        logic [3:0] v;
        v = 4'(i);
`ifdef FFT_OUT_BITREV_EN
        return {v[0], v[1], v[2], v[3]};
`else
        return v;
`endif
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_re, out_im, out_index, out_last, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b re=%h im=%h idx=%0d last=%b busy=%b ovr=%b, required all 0",
                     out_valid, out_re, out_im, out_index, out_last, busy, overrun);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [15:0] exp_re, exp_im;
        data_out = make_frame(16'h0001, 16'h8000);
        endop = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        endop = 1'b0;
        data_out = make_frame(16'h7700, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            exp_re = 16'h0001 + 16'(src_of(i));
            exp_im = 16'h8000 | 16'(src_of(i));
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_index !== 4'(i) || out_re !== exp_re ||
                out_im !== exp_im || out_last !== (i == 15)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: valid=%b busy=%b idx=%0d re=%h im=%h last=%b, required 1 1 %0d %h %h %b",
                         i, out_valid, busy, out_index, out_re, out_im, out_last, i, exp_re, exp_im, i == 15);
            end
            $display("basic beat %0d idx=%0d re=%h im=%h last=%b", i, out_index, out_re, out_im, out_last);
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: valid=%b busy=%b last=%b, required 0 0 0", out_valid, busy, out_last);
        end
    endtask

    task automatic test_backpressure();
        int exp_idx;
        int cyc;
        logic [15:0] exp_re;
        data_out = make_frame(16'h0001, 16'h8000);
        endop = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        endop = 1'b0;
        exp_idx = 0;
        cyc = 0;
        while (exp_idx < 16 && cyc < 100) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            exp_re = 16'h0001 + 16'(src_of(exp_idx));
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 4'(exp_idx) || out_re !== exp_re ||
                out_last !== (exp_idx == 15)) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: valid=%b idx=%0d re=%h last=%b, required 1 %0d %h %b",
                         cyc, out_valid, out_index, out_re, out_last, exp_idx, exp_re, exp_idx == 15);
            end
            $display("bp cycle %0d ready=%b idx=%0d re=%h", cyc, out_ready, out_index, out_re);
            if (out_ready) exp_idx++;
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (exp_idx != 16 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: beats=%0d valid=%b busy=%b, required 16 0 0", exp_idx, out_valid, busy);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_re;
        data_out = make_frame(16'h0001, 16'h8000);
        endop = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        endop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                endop = 1'b1;
                data_out = make_frame(16'h0100, 16'h4000);
            end
            @(negedge clk);
        end
        endop = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_index !== 4'd0 || out_re !== 16'h0100 ||
            out_im !== 16'h4000 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b busy=%b idx=%0d re=%h im=%h ovr=%b, required 1 1 0 0100 4000 0",
                     out_valid, busy, out_index, out_re, out_im, overrun);
        end
        for (int i = 0; i < 16; i++) begin
            exp_re = 16'h0100 + 16'(src_of(i));
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 4'(i) || out_re !== exp_re) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: valid=%b idx=%0d re=%h, required 1 %0d %h",
                         i, out_valid, out_index, out_re, i, exp_re);
            end
            $display("b2b beat %0d idx=%0d re=%h", i, out_index, out_re);
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%b ovr=%b, required 0 0", out_valid, overrun);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] exp_re;
        data_out = make_frame(16'h0001, 16'h8000);
        endop = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        endop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            endop = (i == 5);
            if (i == 5) data_out = make_frame(16'h0F00, 16'h0000);
            exp_re = 16'h0001 + 16'(src_of(i));
            n_checks++;
            if (out_index !== 4'(i) || out_re !== exp_re || overrun !== (i > 5)) begin
                n_fail++;
                $display("FAIL ovr_beat%0d: idx=%0d re=%h ovr=%b, required %0d %h %b",
                         i, out_index, out_re, overrun, i, exp_re, i > 5);
            end
            $display("ovr beat %0d idx=%0d re=%h ovr=%b", i, out_index, out_re, overrun);
            @(negedge clk);
        end
        endop = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_sticky: ovr=%b valid=%b, required 1 0", overrun, out_valid);
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: ovr=%b, required 0", overrun);
        end
        endop = 1'b1;
        @(negedge clk);
        endop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            endop = (i == 3);
            overrun_clr = (i == 3);
            @(negedge clk);
        end
        endop = 1'b0; overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set_wins: ovr=%b, required 1", overrun);
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
    endtask

    task automatic test_mid_reset();
        data_out = make_frame(16'h0001, 16'h8000);
        endop = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        endop = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if (out_index !== 4'd7 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_beat7: idx=%0d valid=%b, required 7 1", out_index, out_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== 4'd0 || out_re !== 16'h0000) begin
            n_fail++;
            $display("FAIL mr_async: valid=%b busy=%b idx=%0d re=%h, required 0 0 0 0000",
                     out_valid, busy, out_index, out_re);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_idle: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        data_out = make_frame(16'h0200, 16'h8000);
        endop = 1'b1;
        @(negedge clk);
        endop = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd0 || out_re !== 16'h0200) begin
            n_fail++;
            $display("FAIL mr_restart: valid=%b idx=%0d re=%h, required 1 0 0200", out_valid, out_index, out_re);
        end
        repeat (16) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_end: valid=%b, required 0", out_valid);
        end
    endtask

`ifdef FFT_OUT_BITREV_EN
    task automatic test_bitrev();
        logic [15:0] exp_tab [16];
        exp_tab = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
                    16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};
        data_out = make_frame(16'h0000, 16'h0000);
        endop = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        endop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (out_index !== 4'(i) || out_re !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL bitrev_beat%0d: idx=%0d re=%0d, required %0d %0d", i, out_index, out_re, i, exp_tab[i]);
            end
            $display("bitrev beat %0d idx=%0d re=%0d", i, out_index, out_re);
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
`ifdef FFT_OUT_BITREV_EN
        test_bitrev();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_out_streamer.md
Name: fft_out_streamer

Overview:
- Unload side of the FFT core: captures the 512-bit parallel result bus when the core pulses endop.
- Streams the captured result as 16 complex samples, one per beat, over a valid/ready interface to downstream logic (UART/DMA formatter).
- Frees the FFT core to start its next transform as soon as capture completes.

Parameters:
- N_POINTS, 16, number of complex samples per transform.
- DATA_W, 16, bits per real or imaginary component.
- IDX_W, 4, sample index width; must equal log2(N_POINTS).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Data_Out  in  2*DATA_W*N_POINTS  FFT result bus. Sample k is bits [2*DATA_W*k +: 2*DATA_W]: real part in the upper DATA_W bits, imaginary part in the lower DATA_W bits.
- endop  in  1  one-cycle pulse from the FFT core; Data_Out is valid in that cycle.
- out_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  beat valid.
- out_re  out  DATA_W  real component of the current sample.
- out_im  out  DATA_W  imaginary component of the current sample.
- out_index  out  IDX_W  frequency-bin index of the current sample.
- out_last  out  1  high on the final beat of a frame.
- busy  out  1  frame captured and not fully streamed.
- overrun  out  1  sticky: an endop was dropped.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (async, active-high), all outputs 0:
  - out_valid=0, out_re=0, out_im=0, out_index=0, out_last=0, busy=0, overrun=0.
  - Capture buffer cleared, state=IDLE, beat counter=0.
- States: IDLE, STREAM.
- IDLE:
  - endop=1 latches all of Data_Out into the internal buffer on that edge.
  - Counter is set to 0 and state moves to STREAM.
  - Latency: out_valid=1 from the next cycle (1 cycle after the endop edge), with out_index=0.
- STREAM:
  - out_valid=1 continuously. out_re/out_im are taken from the buffer sample selected by the counter; out_index = counter.
  - Beat transfers when out_valid && out_ready. The counter advances by 1 per transfer.
  - While out_ready=0, all outputs hold stable; no change is permitted while stalled.
  - out_last=1 when counter=N_POINTS-1.
  - The transfer with out_last=1 ends the frame: state returns to IDLE, out_valid=0 next cycle, counter resets to 0.
- busy=1 exactly while state=STREAM.
- Back-to-back frames:
  - If endop=1 in the same cycle as the last-beat transfer, the new frame is captured.
  - State stays STREAM and out_index=0 appears the next cycle, with no gap cycle.
- Overrun:
  - An endop in STREAM that is not coincident with the last-beat transfer is dropped. The buffer is unchanged and overrun is set.
  - overrun stays 1 until overrun_clr=1. If set and clear occur in the same cycle, set wins.
- Data is passed bit-exact; no arithmetic or format conversion. Counter wrap is never reached because the frame ends at N_POINTS-1.
- Reset mid-stream: frame discarded, out_valid drops immediately (asynchronous), IDLE on release.
- Data_Out is sampled only on a capture edge; changes at other times have no effect.

Optional Feature:
- Macro: FFT_OUT_BITREV_EN.
- Defined:
  - Buffer read address = bit-reverse(counter) over IDX_W bits.
  - out_index still carries the natural-order counter, so natural-order bins come out of a core that produces bit-reversed order.
  - Example: beat 1 reads sample 8; beat 3 reads sample 12.
- Undefined: read address = counter; samples stream in bus order.

Test Plan:
- Basic frame: reset, then one endop with sample k = {re=k+1, im=16'h8000|k}, out_ready held 1 → 16 consecutive beats from the cycle after endop. out_index 0..15, out_re 1..16, out_im 8000..800F, out_last only on index 15, busy falls after that beat.
- Backpressure: same frame, out_ready toggled 1,0,0,1 repeating → values hold during stall cycles, all 16 samples delivered in order, no duplicates or skips, exactly 16 transfers.
- Back-to-back: second endop (sample k re=16'h0100+k) coincident with the last-beat transfer of frame 1 → next cycle out_valid=1, out_index=0, out_re=16'h0100, no idle cycle, overrun=0.
- Overrun: endop at beat 5 of a frame → stream continues with the original data, overrun=1 and sticky. overrun_clr pulse → overrun=0. overrun_clr coincident with a new drop → overrun stays 1.
- Mid-stream reset: assert reset during beat 7 → out_valid/busy=0 immediately. After release, out_valid stays 0 until a new endop, whose frame starts at index 0.
- Build with FFT_OUT_BITREV_EN, sample k re=k → out_re sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_index 0..15.
